// File: rtl/lfsr_stream_checker.sv
// Serial LFSR stream checker: self-synchronises, then predicts each bit free-running and counts mismatches.
// Latency: outputs registered, reflecting the bit sampled on the previous valid edge.
// Backpressure: none; in_valid=0 cycles simply hold state (err_pulse drops, clr_cnt still acts).
module lfsr_stream_checker #(
    parameter int                   LFSR_BITS  = 24,
    parameter logic [LFSR_BITS-1:0] TAP_MASK   = 24'hC00003,
    parameter int                   VERIFY_LEN = 32,
    parameter int                   ERR_WINDOW = 64,
    parameter int                   ERR_THRESH = 4,
    parameter int                   CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W = ($clog2(LFSR_BITS) < 1) ? 1 : $clog2(LFSR_BITS);
    localparam int VCNT_W = ($clog2(VERIFY_LEN) < 1) ? 1 : $clog2(VERIFY_LEN);
    localparam int WIN_W  = ($clog2(ERR_WINDOW) < 1) ? 1 : $clog2(ERR_WINDOW);
    localparam int WERR_W = ($clog2(ERR_THRESH) < 1) ? 1 : $clog2(ERR_THRESH);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_BITS - 1);
    localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(VERIFY_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(ERR_WINDOW - 1);
    localparam logic [WERR_W:0]   THRESH    = (WERR_W + 1)'(ERR_THRESH);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state;
    logic [LFSR_BITS-1:0] c;
    logic [FILL_W-1:0]    fill;
    logic [VCNT_W-1:0]    vcnt;
    logic [WIN_W-1:0]     win;
    logic [WERR_W-1:0]    werr;

    logic                 exp_bit;
    logic                 mism;
    logic [WERR_W:0]      werr_sum;
    logic                 count_bit;
    logic                 count_err;

    always_comb begin
        exp_bit   = ^(c & TAP_MASK);
        mism      = in_bit ^ exp_bit;
        werr_sum  = {1'b0, werr} + {{WERR_W{1'b0}}, mism};
        count_bit = in_valid && (state == LOCKED);
        count_err = count_bit && mism;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            c         <= '0;
            fill      <= '0;
            vcnt      <= '0;
            win       <= '0;
            werr      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        c <= {in_bit, c[LFSR_BITS-1:1]};
                        if (fill == FILL_LAST) begin
                            state <= VERIFY;
                            vcnt  <= '0;
                        end else begin
                            fill <= fill + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        c <= {in_bit, c[LFSR_BITS-1:1]};
                        // An all-zero register predicts zeros forever, so it must never count as a match.
                        if (!mism && (c != '0)) begin
                            if (vcnt == VCNT_LAST) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                win    <= '0;
                                werr   <= '0;
                            end else begin
                                vcnt <= vcnt + VCNT_W'(1);
                            end
                        end else begin
                            state <= SEARCH;
                            fill  <= '0;
                        end
                    end
                    LOCKED: begin
                        err_pulse <= mism;
                        if (werr_sum >= THRESH) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            fill   <= '0;
                            win    <= '0;
                            werr   <= '0;
                            c      <= {in_bit, c[LFSR_BITS-1:1]};
                        end else begin
                            // Feed back the prediction so a corrupted bit does not poison later predictions.
                            c <= {exp_bit, c[LFSR_BITS-1:1]};
                            if (win == WIN_LAST) begin
                                win  <= '0;
                                werr <= '0;
                            end else begin
                                win  <= win + WIN_W'(1);
                                werr <= werr_sum[WERR_W-1:0];
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        fill   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
            bit_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
            bit_count <= '0;
        end else begin
            if (count_bit && (bit_count != '1)) bit_count <= bit_count + CNT_W'(1);
            if (count_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: reference generator drives the stream; per-bit expectations go through a queue.
module tb_lfsr_stream_checker;

    localparam logic [23:0] SEED = 24'd12345;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [31:0] err_count, bit_count;
    logic [3:0]  err_count4, bit_count4;

    always #5 clk = ~clk;

    lfsr_stream_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    lfsr_stream_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4)
    );

    typedef struct {
        logic lk;
        logic ep;
        int   ec;
        int   bc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    exp_t        ein;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] gen;

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic next_bit(output logic b);
        b   = gen[0];
        gen = {^(gen & 24'hC00003), gen[23:1]};
    endtask

    task automatic apply(input logic v, input logic b, input logic clr);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic lk, input logic ep, input int ec, input int bc);
        ein.lk = lk;
        ein.ep = ep;
        ein.ec = ec;
        ein.bc = bc;
        exp_q.push_back(ein);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic lock_up();
        logic b;
        do_reset();
        gen = SEED;
        for (int k = 1; k <= 56; k++) begin
            next_bit(b);
            apply(1'b1, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({locked, locked4, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !== '0) begin
            errors++;
            $display("FAIL reset: got lk=%0b ep=%0b ec=%0d bc=%0d ec4=%0d bc4=%0d want all zero",
                     locked, err_pulse, err_count, bit_count, err_count4, bit_count4);
        end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        logic b;
        do_reset();
        gen = SEED;
        for (int k = 1; k <= 100; k++) begin
            next_bit(b);
            push_exp(k >= 56, 1'b0, 0, (k >= 57) ? k - 56 : 0);
            apply(1'b1, b, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, locked4, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !==
                {e.lk, e.lk, e.ep, e.ep, 32'(e.ec), 32'(e.bc), 4'(sat15(e.ec)), 4'(sat15(e.bc))}) begin
                errors++;
                $display("FAIL lock bit %0d: got lk=%0b ep=%0b ec=%0d bc=%0d bc4=%0d want lk=%0b ep=%0b ec=%0d bc=%0d",
                         k, locked, err_pulse, err_count, bit_count, bit_count4, e.lk, e.ep, e.ec, e.bc);
            end
        end
    endtask

    task automatic test_single_error();
        logic b, bad;
        int   ec = 0;
        lock_up();
        for (int j = 1; j <= 60; j++) begin
            next_bit(b);
            bad = (j == 21);
            if (bad) ec++;
            push_exp(1'b1, bad, ec, j);
            apply(1'b1, b ^ bad, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, locked4, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !==
                {e.lk, e.lk, e.ep, e.ep, 32'(e.ec), 32'(e.bc), 4'(sat15(e.ec)), 4'(sat15(e.bc))}) begin
                errors++;
                $display("FAIL single_error bit %0d: got lk=%0b ep=%0b ec=%0d bc=%0d want lk=%0b ep=%0b ec=%0d bc=%0d",
                         j, locked, err_pulse, err_count, bit_count, e.lk, e.ep, e.ec, e.bc);
            end
        end
    endtask

    task automatic test_burst();
        logic b, bad;
        int   ec = 0;
        lock_up();
        for (int j = 1; j <= 70; j++) begin
            next_bit(b);
            bad = (j >= 5) && (j <= 8);
            if (bad) ec++;
            push_exp((j < 8) || (j >= 64), bad, ec, (j <= 8) ? j : ((j <= 64) ? 8 : j - 56));
            apply(1'b1, b ^ bad, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, locked4, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !==
                {e.lk, e.lk, e.ep, e.ep, 32'(e.ec), 32'(e.bc), 4'(sat15(e.ec)), 4'(sat15(e.bc))}) begin
                errors++;
                $display("FAIL burst bit %0d: got lk=%0b ep=%0b ec=%0d bc=%0d want lk=%0b ep=%0b ec=%0d bc=%0d",
                         j, locked, err_pulse, err_count, bit_count, e.lk, e.ep, e.ec, e.bc);
            end
        end
    endtask

    task automatic test_window();
        logic b, bad;
        int   ec = 0;
        int   pos;
        lock_up();
        for (int j = 1; j <= 640; j++) begin
            next_bit(b);
            pos = (j - 1) % 64 + 1;
            bad = (pos == 10) || (pos == 30) || (pos == 50);
            if (bad) ec++;
            push_exp(1'b1, bad, ec, j);
            apply(1'b1, b ^ bad, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, locked4, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !==
                {e.lk, e.lk, e.ep, e.ep, 32'(e.ec), 32'(e.bc), 4'(sat15(e.ec)), 4'(sat15(e.bc))}) begin
                errors++;
                $display("FAIL window bit %0d: got lk=%0b ep=%0b ec=%0d bc=%0d ec4=%0d want lk=%0b ep=%0b ec=%0d bc=%0d",
                         j, locked, err_pulse, err_count, bit_count, err_count4, e.lk, e.ep, e.ec, e.bc);
            end
        end
    endtask

    task automatic test_zeros();
        do_reset();
        for (int j = 1; j <= 500; j++) begin
            push_exp(1'b0, 1'b0, 0, 0);
            apply(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, locked4, err_pulse, err_count, bit_count} !== {e.lk, e.lk, e.ep, 32'(e.ec), 32'(e.bc)}) begin
                errors++;
                $display("FAIL zeros bit %0d: got lk=%0b ep=%0b ec=%0d bc=%0d want lk=0 ep=0 ec=0 bc=0",
                         j, locked, err_pulse, err_count, bit_count);
            end
        end
    endtask

    task automatic test_gaps();
        logic b, v;
        int   vk = 0;
        do_reset();
        gen = SEED;
        for (int cyc = 0; (cyc < 1000) && (vk < 120); cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                next_bit(b);
                vk++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            push_exp(vk >= 56, 1'b0, 0, (vk >= 57) ? vk - 56 : 0);
            apply(v, b, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, locked4, err_pulse, err_count, bit_count, bit_count4} !==
                {e.lk, e.lk, e.ep, 32'(e.ec), 32'(e.bc), 4'(sat15(e.bc))}) begin
                errors++;
                $display("FAIL gaps cycle %0d valid %0d: got lk=%0b ep=%0b ec=%0d bc=%0d want lk=%0b ep=0 ec=0 bc=%0d",
                         cyc, vk, locked, err_pulse, err_count, bit_count, e.lk, e.bc);
            end
        end
        checks++;
        if (vk != 120) begin
            errors++;
            $display("FAIL gaps budget: got %0d valid bits want 120", vk);
        end
    endtask

    task automatic test_clr();
        logic b, bad, v, clr;
        int   ec = 0;
        int   bc = 0;
        lock_up();
        for (int j = 1; j <= 22; j++) begin
            v   = (j != 21);
            bad = (j == 11) || (j == 20);
            clr = (j == 11) || (j == 16) || (j == 21);
            b   = 1'b0;
            if (v) next_bit(b);
            if (clr) begin
                ec = 0;
                bc = 0;
            end else if (v) begin
                bc++;
                if (bad) ec++;
            end
            push_exp(1'b1, bad, ec, bc);
            apply(v, b ^ bad, clr);
            e = exp_q.pop_front();
            checks++;
            if ({locked, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !==
                {e.lk, e.ep, e.ep, 32'(e.ec), 32'(e.bc), 4'(sat15(e.ec)), 4'(sat15(e.bc))}) begin
                errors++;
                $display("FAIL clr step %0d: got lk=%0b ep=%0b ec=%0d bc=%0d want lk=%0b ep=%0b ec=%0d bc=%0d",
                         j, locked, err_pulse, err_count, bit_count, e.lk, e.ep, e.ec, e.bc);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic b, bad;
        lock_up();
        for (int j = 1; j <= 10; j++) begin
            next_bit(b);
            bad = (j == 10);
            apply(1'b1, b ^ bad, 1'b0);
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({locked, locked4, err_pulse, err_pulse4, err_count, bit_count, err_count4, bit_count4} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got lk=%0b ep=%0b ec=%0d bc=%0d want all zero",
                     locked, err_pulse, err_count, bit_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            next_bit(b);
            push_exp(k >= 56, 1'b0, 0, (k >= 57) ? k - 56 : 0);
            apply(1'b1, b, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({locked, err_pulse, err_count, bit_count} !== {e.lk, e.ep, 32'(e.ec), 32'(e.bc)}) begin
                errors++;
                $display("FAIL reacquire bit %0d: got lk=%0b ep=%0b ec=%0d bc=%0d want lk=%0b ep=0 ec=0 bc=%0d",
                         k, locked, err_pulse, err_count, bit_count, e.lk, e.bc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_burst();
        test_window();
        test_zeros();
        test_gaps();
        test_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receiving-end checker for the serial pseudo-random stream produced by the simulator's LFSR generators.
- Self-synchronises to the incoming bit stream and then predicts each following bit from its own copy of the LFSR.
- Counts mismatches, and drops lock when the error density is too high.
- Used on the FPGA side to validate generator-driven hit data paths before data is exported to the HPS.

Parameters:
- LFSR_BITS, 24: register length N; must be ≥ 2.
- TAP_MASK, 24'hC00003: feedback tap i is used when bit i is 1 (default taps are 0, 1, 22, 23).
- VERIFY_LEN, 32: number of consecutive correct predictions required before lock is declared; must be ≥ 1.
- ERR_WINDOW, 64: length, in checked bits, of the error-density window used while locked.
- ERR_THRESH, 4: number of errors within one window that forces loss of lock; must be ≥ 1.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk, in, 1: system clock; everything is on the rising edge.
- rst, in, 1: asynchronous, active-low reset; assertion is asynchronous.
- in_valid, in, 1: in_bit is sampled on edges where in_valid=1.
- in_bit, in, 1: received stream bit; the stream equals successive lfsr[0] values of a generator with the same N and TAP_MASK.
- clr_cnt, in, 1: synchronous clear of err_count and bit_count.
- locked, out, 1: high while the FSM is in the LOCKED state.
- err_pulse, out, 1: one-cycle pulse for a mismatched bit while locked.
- err_count, out, CNT_W: saturating count of mismatches while locked.
- bit_count, out, CNT_W: saturating count of bits checked while locked.

Behaviour:
- Generator model:
  - r_next = {fb, r[N-1:1]}, with fb = XOR of r[i] over all i where TAP_MASK[i]=1.
  - The stream bit emitted each step is r[0].
- Shadow register c (N bits):
  - A shift is c <= {b, c[N-1:1]}.
  - The prediction is exp = XOR of c[i] over all i where TAP_MASK[i]=1.
- Reset (rst=0):
  - c=0, state=SEARCH, fill=0, vcnt=0, win=0, werr=0.
  - locked=0, err_pulse=0, err_count=0, bit_count=0.
  - Asynchronous reset mid-lock aborts immediately; the block must re-acquire from SEARCH after reset is released.
- in_valid=0: no register changes, except err_pulse, which returns to 0, and clr_cnt, which still acts.
- SEARCH:
  - Each valid bit shifts in_bit into c and increments fill.
  - When fill reaches N-1 on a valid bit, the next state is VERIFY with vcnt=0.
- VERIFY:
  - Each valid bit shifts in_bit into c (received bit, not exp).
  - Match (in_bit==exp) with c≠0 before the shift: vcnt++. If vcnt reaches VERIFY_LEN-1 on that bit, go to LOCKED with win=0 and werr=0.
  - Mismatch, or c==0 before the shift: go to SEARCH with fill=0.
  - Consequence: an all-zero stream never locks.
- LOCKED, free-running prediction:
  - Each valid bit shifts exp into c, never in_bit.
  - bit_count++ (saturating at all-ones).
  - On mismatch: err_pulse=1 on the next cycle, err_count++ (saturating), werr++.
  - win increments per valid bit. On the bit that makes win=ERR_WINDOW-1, win and werr reset to 0, after that bit's error is evaluated.
  - If werr+mismatch reaches ERR_THRESH: go to SEARCH with fill=0 and shift in_bit into c. err_pulse still fires for that bit, and the counters still update.
- Latency: all outputs are registered and reflect the bit sampled on the previous valid edge. locked rises on the edge that samples the (N+VERIFY_LEN)-th valid bit of a clean stream.
- clr_cnt:
  - err_count=0 and bit_count=0 next edge.
  - If clr_cnt coincides with a counting event, the clear wins and the result is 0.
  - clr_cnt does not affect the FSM, win or werr.
- Arithmetic: counters use unsigned saturating adds. fill, vcnt and win are sized with $clog2 of their limits, minimum 1 bit.

Test Plan:
- Lock acquisition: drive the stream from a model generator with default parameters, seed 24'd12345, in_valid=1 every cycle.
  - locked=0 through bit 55; locked=1 after bit 56 is sampled.
  - err_count stays 0 and bit_count increments by 1 per cycle.
- Single error: after lock, invert one bit.
  - Exactly one err_pulse cycle; err_count=1; locked stays 1.
  - The following bits match again, because prediction is free-running.
- Burst unlock: invert 4 bits within 64 checked bits → locked=0 the cycle after the 4th error, err_count=4. Clean stream afterwards → relock after 56 further valid bits.
- Window spacing: 3 errors per 64-bit window, repeated for 10 windows → locked stays 1, err_count=30.
- Edge cases:
  - All-zero stream of 500 bits → locked never asserts.
  - Random in_valid gaps on a clean stream → same lock point measured in valid bits; bit_count equals the number of valid bits while locked.
- Control and counters:
  - Pull rst low mid-lock → all outputs 0 immediately.
  - clr_cnt held together with a mismatch → err_count=0.
  - Force bit_count to saturate via CNT_W=4 → bit_count holds at 15.
